// File: rtl/aib_axi_credit_gate.sv
// Credit gate between the AXI-MM slave port and the AIB packetiser.
// Holds all channels closed until the link is up, then spends one credit per handshake and accumulates returns.
module aib_axi_credit_gate #(
    parameter int NUM_CH   = 3,
    parameter int CREDIT_W = 8,
    parameter int RET_W    = 2,
    parameter int DELAY_W  = 16
) (
    input  logic                         clk_wr,
    input  logic                         rst_wr,
    input  logic                         ns_mac_rdy,
    input  logic                         fs_mac_rdy,
    input  logic [DELAY_W-1:0]           start_delay,
    input  logic [NUM_CH*CREDIT_W-1:0]   init_credit,
    input  logic [NUM_CH-1:0]            s_valid,
    output logic [NUM_CH-1:0]            s_ready,
    output logic [NUM_CH-1:0]            m_valid,
    input  logic [NUM_CH-1:0]            m_ready,
    input  logic [NUM_CH*RET_W-1:0]      credit_ret,
    input  logic                         err_clr,
    output logic [NUM_CH*CREDIT_W-1:0]   credit_avail,
    output logic                         link_up,
    output logic [NUM_CH-1:0]            ovf_err
);
    localparam int SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DLY, S_LOAD, S_ACTIVE} state_t;

    state_t             state_q;
    logic [DELAY_W-1:0] dly_q;
    logic               link_q;
    logic               both_rdy;

    assign both_rdy = ns_mac_rdy && fs_mac_rdy;
    assign link_up  = link_q;

    // Losing either MAC from any state drops straight back to IDLE.
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state_q <= S_IDLE;
            dly_q   <= '0;
            link_q  <= 1'b0;
        end else if (!both_rdy) begin
            state_q <= S_IDLE;
            link_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_DLY;
                    dly_q   <= start_delay;
                end
                S_DLY: begin
                    if (dly_q == '0) state_q <= S_LOAD;
                    else             dly_q   <= dly_q - DELAY_W'(1);
                end
                S_LOAD: begin
                    state_q <= S_ACTIVE;
                    link_q  <= 1'b1;
                end
                S_ACTIVE: state_q <= S_ACTIVE;
                default: begin
                    state_q <= S_IDLE;
                    link_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CREDIT_W-1:0] cred_q, cred_d;
        logic                ovf_q, ovf_d;
        logic                open_w, take_w;
        logic [SUM_W-1:0]    sum_w;

        assign open_w     = link_q && (cred_q != '0);
        assign m_valid[i] = s_valid[i] && open_w;
        assign s_ready[i] = m_ready[i] && open_w;
        assign take_w     = s_valid[i] && m_ready[i] && open_w;
        // take implies cred_q != 0, so the subtraction never wraps
        assign sum_w = {1'b0, cred_q} - SUM_W'(take_w)
                     + SUM_W'(credit_ret[i*RET_W +: RET_W]);

        always_comb begin
            cred_d = cred_q;
            ovf_d  = err_clr ? 1'b0 : ovf_q;
            if (!both_rdy) begin
                cred_d = '0;
            end else if (state_q == S_LOAD) begin
                cred_d = init_credit[i*CREDIT_W +: CREDIT_W];
            end else if (state_q == S_ACTIVE) begin
                if (sum_w[CREDIT_W]) begin
                    cred_d = '1;
                    ovf_d  = 1'b1;
                end else begin
                    cred_d = sum_w[CREDIT_W-1:0];
                end
            end
        end

        always_ff @(posedge clk_wr or posedge rst_wr) begin
            if (rst_wr) begin
                cred_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                cred_q <= cred_d;
                ovf_q  <= ovf_d;
            end
        end

        assign credit_avail[i*CREDIT_W +: CREDIT_W] = cred_q;
        assign ovf_err[i] = ovf_q;
    end
endmodule

// File: tb/tb_aib_axi_credit_gate.sv
// Bench for aib_axi_credit_gate: directed start-up/exhaust/return/saturation/drop/reset steps
// plus random traffic, all checked against a count-based reference model.
module tb_aib_axi_credit_gate;
    localparam int NC = 3;
    localparam int CW = 8;
    localparam int RW = 2;
    localparam int DW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk_wr = 1'b0;
    logic              rst_wr;
    logic              ns_mac_rdy, fs_mac_rdy;
    logic [DW-1:0]     start_delay;
    logic [NC*CW-1:0]  init_credit;
    logic [NC-1:0]     s_valid, s_ready, m_valid, m_ready;
    logic [NC*RW-1:0]  credit_ret;
    logic              err_clr;
    logic [NC*CW-1:0]  credit_avail;
    logic              link_up;
    logic [NC-1:0]     ovf_err;

    int total = 0;
    int bad   = 0;

    // Reference model: link comes up a fixed number of consecutive ready edges after start.
    int m_hi;
    int m_d;
    bit m_link;
    int m_cred [NC];
    bit m_ovf  [NC];

    aib_axi_credit_gate #(.NUM_CH(NC), .CREDIT_W(CW), .RET_W(RW), .DELAY_W(DW)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .ns_mac_rdy(ns_mac_rdy), .fs_mac_rdy(fs_mac_rdy),
        .start_delay(start_delay), .init_credit(init_credit), .s_valid(s_valid),
        .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .credit_ret(credit_ret),
        .err_clr(err_clr), .credit_avail(credit_avail), .link_up(link_up), .ovf_err(ovf_err)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*CW-1:0] exp_cred();
        logic [NC*CW-1:0] v = '0;
        for (int c = 0; c < NC; c++) v[c*CW +: CW] = CW'(m_cred[c]);
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_ovf();
        logic [NC-1:0] v = '0;
        for (int c = 0; c < NC; c++) v[c] = m_ovf[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] exp_open();
        logic [NC-1:0] v = '0;
        for (int c = 0; c < NC; c++) v[c] = m_link && (m_cred[c] != 0);
        return v;
    endfunction

    task automatic model_reset();
        m_hi = 0; m_d = 0; m_link = 0;
        for (int c = 0; c < NC; c++) begin m_cred[c] = 0; m_ovf[c] = 0; end
    endtask

    task automatic model_edge();
        bit newlink;
        int s, take, ret;
        bit ovf_n;
        if (!(ns_mac_rdy && fs_mac_rdy)) begin
            m_hi = 0; m_link = 0;
            for (int c = 0; c < NC; c++) begin
                m_cred[c] = 0;
                if (err_clr) m_ovf[c] = 0;
            end
            return;
        end
        if (m_hi == 0) m_d = int'(start_delay);
        m_hi++;
        newlink = (m_hi >= m_d + 3);
        for (int c = 0; c < NC; c++) begin
            ovf_n = err_clr ? 1'b0 : m_ovf[c];
            if (m_link) begin
                take = (s_valid[c] && m_ready[c] && m_cred[c] != 0) ? 1 : 0;
                ret  = int'(credit_ret[c*RW +: RW]);
                s    = m_cred[c] - take + ret;
                if (s > CMAX) begin m_cred[c] = CMAX; ovf_n = 1; end
                else m_cred[c] = s;
            end else if (newlink) begin
                m_cred[c] = int'(init_credit[c*CW +: CW]);
            end
            m_ovf[c] = ovf_n;
        end
        m_link = newlink;
    endtask

    // One clock: check gating with current inputs, advance model, check registered state.
    task automatic cyc();
        logic [NC-1:0] op;
        #1;
        op = exp_open();
        chk("m_valid", m_valid, s_valid & op);
        chk("s_ready", s_ready, m_ready & op);
        model_edge();
        @(posedge clk_wr); #1;
        chk("link_up", link_up, m_link);
        chk("credit_avail", credit_avail, exp_cred());
        chk("ovf_err", ovf_err, exp_ovf());
    endtask

    initial begin
        int hs;
        rst_wr = 1; ns_mac_rdy = 0; fs_mac_rdy = 0; start_delay = '0; init_credit = '0;
        s_valid = '0; m_ready = '0; credit_ret = '0; err_clr = 0;
        model_reset();
        repeat (2) @(posedge clk_wr);
        #1 rst_wr = 0;
        s_valid = '1; m_ready = '1;
        #1;
        chk("rst_link", link_up, 1'b0);
        chk("rst_cred", credit_avail, '0);
        chk("rst_ovf", ovf_err, '0);
        chk("rst_mvalid", m_valid, '0);
        chk("rst_sready", s_ready, '0);

        // start-up with delay 5
        s_valid = '0; start_delay = 16'd5; init_credit = {8'd4, 8'd2, 8'd3};
        ns_mac_rdy = 1; fs_mac_rdy = 1;
        for (int j = 0; j < 8; j++) begin
            cyc();
            chk("startup_link", link_up, (j == 7));
        end
        chk("startup_cred", credit_avail, 24'h040203);

        // exhaust AW
        s_valid = 3'b001; m_ready = 3'b111; hs = 0;
        repeat (4) begin
            #1; hs += int'(m_valid[0] && m_ready[0]);
            cyc();
        end
        chk("exhaust_hs", hs, 3);
        chk("exhaust_cred", credit_avail, 24'h040200);
        chk("exhaust_sready0", s_ready[0], 1'b0);

        // returns
        s_valid = '0; credit_ret = 6'b000011;
        cyc();
        credit_ret = '0;
        chk("ret3", credit_avail[7:0], 8'd3);
        s_valid = 3'b001;
        repeat (2) cyc();
        credit_ret = 6'b000010;
        cyc();
        chk("take_ret2", credit_avail[7:0], 8'd2);

        // saturation on AR
        s_valid = '0;
        while (m_cred[1] < CMAX - 4) begin credit_ret = 6'b001100; cyc(); end
        credit_ret = 6'((254 - m_cred[1]) << 2);
        cyc();
        chk("sat_254", credit_avail[15:8], 8'd254);
        credit_ret = 6'b001100;
        cyc();
        chk("sat_255", credit_avail[15:8], 8'd255);
        chk("sat_ovf", ovf_err[1], 1'b1);
        credit_ret = '0;
        cyc();
        chk("ovf_sticky", ovf_err[1], 1'b1);
        err_clr = 1;
        cyc();
        chk("ovf_clr", ovf_err[1], 1'b0);
        credit_ret = 6'b001100;
        cyc();
        err_clr = 0; credit_ret = '0;
        chk("ovf_set_wins", ovf_err[1], 1'b1);

        // random traffic with occasional link drops
        repeat (300) begin
            s_valid     = 3'($urandom);
            m_ready     = 3'($urandom);
            credit_ret  = 6'($urandom);
            err_clr     = ($urandom_range(0, 15) == 0);
            fs_mac_rdy  = ($urandom_range(0, 39) != 0);
            start_delay = 16'($urandom_range(0, 3));
            cyc();
        end

        // link drop mid-burst, returns ignored while down
        err_clr = 0; credit_ret = '0; s_valid = '0; fs_mac_rdy = 1; start_delay = 16'd1;
        repeat (8) cyc();
        s_valid = '1; m_ready = '1;
        cyc();
        fs_mac_rdy = 0;
        cyc();
        #1;
        chk("drop_link", link_up, 1'b0);
        chk("drop_cred", credit_avail, '0);
        chk("drop_mvalid", m_valid, '0);
        credit_ret = '1; fs_mac_rdy = 1; start_delay = 16'd2;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("relink", link_up, (j == 4));
        end
        chk("relink_cred", credit_avail, 24'h040203);
        credit_ret = '0;
        repeat (2) cyc();

        // asynchronous reset between edges
        #2 rst_wr = 1;
        #1;
        chk("arst_link", link_up, 1'b0);
        chk("arst_cred", credit_avail, '0);
        chk("arst_ovf", ovf_err, '0);
        chk("arst_mvalid", m_valid, '0);
        chk("arst_sready", s_ready, '0);
        model_reset();
        @(posedge clk_wr); #1;
        rst_wr = 0;
        start_delay = 16'd0;
        repeat (4) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aib_axi_credit_gate.md
# aib_axi_credit_gate

Parametrised credit-gating stage between the AXI-MM slave port of the AIB/AXI bridge master and its AIB packetiser. It generalises the fixed AW/AR/W initial-credit inputs to NUM_CH independently credited channels. A start-up sequencer holds all channels closed until both MACs are ready and a programmable settle delay has elapsed. After that it loads the initial credits, passes valid/ready handshakes only while credit is available, and accumulates multi-credit returns from the far side with saturation and sticky overflow flags.

## Interface
Parameters:
- NUM_CH, 3, number of credited channels (0=AW, 1=AR, 2=W by convention)
- CREDIT_W, 8, width of each credit counter
- RET_W, 2, width of per-channel credit-return count per cycle
- DELAY_W, 16, width of start-up delay

Ports:
- clk_wr  in  1  single clock; all logic on rising edge
- rst_wr  in  1  reset, asynchronous, active-high
- ns_mac_rdy  in  1  near-side MAC ready
- fs_mac_rdy  in  1  far-side MAC ready
- start_delay  in  DELAY_W  settle cycles after both ready
- init_credit  in  NUM_CH*CREDIT_W  initial credits, channel i at [i*CREDIT_W +: CREDIT_W]
- s_valid  in  NUM_CH  upstream valid per channel
- s_ready  out  NUM_CH  upstream ready per channel
- m_valid  out  NUM_CH  downstream valid per channel
- m_ready  in  NUM_CH  downstream ready per channel
- credit_ret  in  NUM_CH*RET_W  credits returned this cycle, channel i at [i*RET_W +: RET_W]
- err_clr  in  1  clears all overflow flags
- credit_avail  out  NUM_CH*CREDIT_W  current credit counts
- link_up  out  1  high in ACTIVE
- ovf_err  out  NUM_CH  sticky credit-overflow flag per channel

## Operation
- FSM states: IDLE, DLY, LOAD, ACTIVE.
  - IDLE: both rdy high → DLY, with the delay counter loaded with start_delay.
  - DLY: counter==0 → LOAD; otherwise decrement.
  - LOAD: sample init_credit into the counters → ACTIVE.
  - ACTIVE: stays until a rdy drops.
- Either rdy low in any non-IDLE state → IDLE next edge. Credit counters clear to 0 on that edge; ovf_err is retained.
- link_up is registered and equals (state==ACTIVE).
- Gating is combinational, with open[i] = link_up && credit[i]!=0:
  - m_valid[i] = s_valid[i] && open[i]
  - s_ready[i] = m_ready[i] && open[i]
- Consume: take[i] = m_valid[i] && m_ready[i]. Each handshake costs exactly one credit.
- Update in ACTIVE: sum = credit − take + credit_ret, computed at CREDIT_W+1 bits.
  - If sum > 2^CREDIT_W−1, the counter saturates at 2^CREDIT_W−1 and ovf_err[i] sets.
  - Underflow is impossible, because take requires credit≠0.
- credit_ret is ignored outside ACTIVE, including in LOAD.
- Simultaneous take and return in one cycle apply the net value. Example: credit 0 can never take, but credit 1 with take and ret=1 stays at 1.
- err_clr clears ovf_err. If a new overflow occurs in the same cycle, set wins.
- Reset values: state IDLE, link_up 0, credit_avail all 0, ovf_err 0, delay counter 0. Hence s_ready=0 and m_valid=0.
- Reset mid-traffic aborts immediately (asynchronously); no handshake completes in the reset cycle.

## Timing
- If both rdy are first sampled high at edge k, the state is DLY after k, LOAD after k+start_delay+1, and ACTIVE after k+start_delay+2.
- link_up and the loaded credit_avail therefore first appear together after edge k+start_delay+2.
- start_delay=0 gives the minimum: ACTIVE after k+2.
- Gating latency is zero cycles (combinational from s_valid/m_ready/credit).
- Credit change latency is one cycle. credit_avail reflects a take or return on the edge ending that cycle, so a channel at credit 1 that handshakes shows s_ready=0 in the next cycle unless a return arrives in the same cycle.
- rdy drop at edge j: link_up=0 and credits 0 after j; gating closes from that cycle onward.

## Test plan
- Start-up: start_delay=5, init_credit={W:4,AR:2,AW:3}, rdy both high at edge k → link_up 0 through edge k+6, 1 after k+7; credit_avail={4,2,3} after k+7.
- Exhaust: AW s_valid held, m_ready=1 → exactly 3 handshakes on consecutive cycles. Then m_valid[0]=0, s_ready[0]=0, credit 0, other channels unaffected.
- Return: AW at 0, credit_ret[0]=3 for one cycle → credit 3 next cycle. Concurrent take with ret=2 at credit 1 → credit 2.
- Saturation: CREDIT_W=8, credit 254, ret=3 → credit 255, ovf_err[i]=1 sticky; err_clr pulse → 0; err_clr and overflow together → stays 1.
- Link drop: fs_mac_rdy falls mid-burst → next cycle link_up=0, all credits 0, no m_valid. credit_ret during IDLE/DLY/LOAD has no effect. Re-raising rdy repeats the start-up timing.
- Async reset asserted mid-ACTIVE between edges → outputs go to reset values immediately without a clock edge.
